// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings and
// the largest supported requester count (the contents of uart_defs.v).
// Optional feature macro used by this block: UART_TX_ARB_LOCK_EN.
package uart_tx_arb_pkg;

  // Encodings are fixed so debug taps and checkers can decode them directly.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  // Largest number of requesters the arbiter is built for.
  localparam int MAX_N = 8;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester/transmitter bundle of the UART transmit arbiter.
// Handshake: requester i raises req_valid[i] with req_data[i] and holds both
// until the arbiter pulses req_ack[i] for one cycle; the arbiter pulses
// tx_strobe for one cycle with tx_data, and the transmitter reports idle on
// tx_ready (it drops after a strobe and rises after the stop bit).
// With UART_TX_ARB_LOCK_EN defined, req_last[i] marks a message's final byte.
interface uart_tx_arb_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  import uart_tx_arb_pkg::*;

  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N-1:0]   req_last;
`endif
  logic [7:0]     tx_data;
  logic           tx_strobe;
  logic           tx_ready;
  logic [IDW-1:0] owner;
  logic           busy;
  state_t         dbg_state;

`ifdef UART_TX_ARB_LOCK_EN
  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ack, tx_data, tx_strobe, owner, busy, dbg_state
  );
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ack, tx_data, tx_strobe, owner, busy, dbg_state
  );
`else
  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ack, tx_data, tx_strobe, owner, busy, dbg_state
  );
  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ack, tx_data, tx_strobe, owner, busy, dbg_state
  );
`endif

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Rotating-priority search: starting at base and ascending with wrap-around,
// report the first set bit of req.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] base,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [N-1:0] rot;
  logic [IDW:0] sum;

  // Rotate so bit 0 is the base position, then take the lowest set bit.
  always_comb begin
    rot   = N'({req, req} >> base);
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, base} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
        idx   = sum[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding N byte requesters into one UART transmitter.
// Optional macro UART_TX_ARB_LOCK_EN: keep the grant on one requester until
// it sends a byte flagged by req_last.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_arb_if.slave  bus
);

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_strobe_q, tx_strobe_d;
  logic [N-1:0]   req_ack_q, req_ack_d;
`ifdef UART_TX_ARB_LOCK_EN
  logic           lock_q, lock_d;
`endif

  logic [IDW:0]   base_sum;
  logic [IDW-1:0] base;
  logic [N-1:0]   cand;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;

  // Search starts one past the last owner, wrapping at N.
  always_comb begin
    base_sum = {1'b0, owner_q} + (IDW+1)'(1);
    if (base_sum >= (IDW+1)'(N)) base_sum = '0;
    base = base_sum[IDW-1:0];
  end

  // Candidate requests; a held lock narrows them to the current owner.
  always_comb begin
    cand = bus.req_valid;
`ifdef UART_TX_ARB_LOCK_EN
    if (lock_q) cand = bus.req_valid & (N'(1) << owner_q);
`endif
  end

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (cand),
    .base  (base),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state logic; strobe and ack are registered so they appear in SEND.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    tx_data_d   = tx_data_q;
    tx_strobe_d = 1'b0;
    req_ack_d   = '0;
`ifdef UART_TX_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.tx_ready && pick_found) begin
          state_d     = SEND;
          owner_d     = pick_idx;
          tx_strobe_d = 1'b1;
          req_ack_d   = N'(1) << pick_idx;
          for (int i = 0; i < N; i++) begin
            if (pick_idx == IDW'(i)) tx_data_d = bus.req_data[8*i +: 8];
          end
`ifdef UART_TX_ARB_LOCK_EN
          lock_d      = !bus.req_last[pick_idx];
`endif
        end
      end
      SEND:      state_d = WAIT_LOW;
      // tx_ready can still read high right after the strobe; wait for the fall.
      WAIT_LOW:  if (!bus.tx_ready) state_d = WAIT_HIGH;
      WAIT_HIGH: if (bus.tx_ready)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any byte in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= IDW'(N-1);
      tx_data_q   <= '0;
      tx_strobe_q <= 1'b0;
      req_ack_q   <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      tx_data_q   <= tx_data_d;
      tx_strobe_q <= tx_strobe_d;
      req_ack_q   <= req_ack_d;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_strobe = tx_strobe_q;
  assign bus.req_ack   = req_ack_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb (N=4): directed vector table plus hand-written
// sequences for fairness, stale ready, mid-byte reset and message lock.
// Builds with or without UART_TX_ARB_LOCK_EN.
module tb_uart_tx_arb;
  import uart_tx_arb_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int W   = IDW + 8;

  // ---------------- clock / reset / DUT ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.N(N), .IDW(IDW)) bus ();
  uart_tx_arb #(.N(N), .IDW(IDW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [N-1:0] req_last_tb = '0;
`ifdef UART_TX_ARB_LOCK_EN
  assign bus.req_last = req_last_tb;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transmitter model ----------------
  logic model_en  = 1'b0;
  int   stale_len = 0;
  int   busy_len  = 0;
  int   st_cnt    = 0;
  int   lo_cnt    = 0;
  always @(negedge clk) begin
    if (model_en) begin
      if (bus.tx_strobe) begin
        st_cnt = stale_len;
        lo_cnt = busy_len;
      end else if (st_cnt > 0) begin
        st_cnt--;
        bus.tx_ready = 1'b1;
      end else if (lo_cnt > 0) begin
        lo_cnt--;
        bus.tx_ready = 1'b0;
      end else begin
        bus.tx_ready = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic       mon_en     = 1'b0;
  logic [7:0] mon_data   = '0;
  logic       stable_bad = 1'b0;
  logic       ack_bad    = 1'b0;
  logic [W-1:0] e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.tx_strobe) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: owner %0d data 0x%0h, no grant expected", bus.owner, bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("grant_owner", 32'(bus.owner), 32'(e[W-1:8]));
          check("grant_data", 32'(bus.tx_data), 32'(e[7:0]));
          check("grant_ack", 32'(bus.req_ack), 32'(1) << e[W-1:8]);
        end
        mon_data = bus.tx_data;
      end else begin
        if (bus.req_ack != '0) ack_bad = 1'b1;
        if ((bus.dbg_state == WAIT_LOW || bus.dbg_state == WAIT_HIGH) && bus.tx_data !== mon_data)
          stable_bad = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    model_en      = 1'b0;
    mon_en        = 1'b0;
    st_cnt        = 0;
    lo_cnt        = 0;
    bus.req_valid = '0;
    bus.tx_ready  = 1'b1;
    req_last_tb   = '0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    while ((exp_q.size() != 0 || bus.busy) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_in_budget", 32'(cyc < budget), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]   valid;
    logic           ready;
    logic           strobe;
    logic [N-1:0]   ack;
    logic [IDW-1:0] owner;
    logic [7:0]     data;
  } vec_t;
  vec_t vecs[11];

  initial begin : main
    bus.req_valid = '0;
    bus.req_data  = 32'h4433_2255;
    bus.tx_ready  = 1'b1;

    // Requester bytes: r0=55 r1=22 r2=33 r3=44. Owner starts at 3.
    vecs[0]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h55};
    vecs[1]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h55};
    vecs[2]  = '{4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3, 8'h44};
    vecs[3]  = '{4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h55};
    vecs[4]  = '{4'b0110, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h22};
    vecs[5]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 2'd1, 8'h22};
    vecs[6]  = '{4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h55};
    vecs[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h55};
    vecs[8]  = '{4'b1100, 1'b1, 1'b1, 4'b0100, 2'd2, 8'h33};
    vecs[9]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 8'h44};
    vecs[10] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h55};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    check("reset_strobe", 32'(bus.tx_strobe), 32'd0);
    check("reset_ack", 32'(bus.req_ack), 32'd0);
    check("reset_tx_data", 32'(bus.tx_data), 32'd0);
    check("reset_owner", 32'(bus.owner), 32'd3);
    check("reset_busy", 32'(bus.busy), 32'd0);

    // Table: one grant decision per vector, then a manual return to IDLE.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.req_valid = vecs[i].valid;
      bus.tx_ready  = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d_strobe", i), 32'(bus.tx_strobe), 32'(vecs[i].strobe));
      check($sformatf("vec%0d_ack", i), 32'(bus.req_ack), 32'(vecs[i].ack));
      check($sformatf("vec%0d_owner", i), 32'(bus.owner), 32'(vecs[i].owner));
      check($sformatf("vec%0d_data", i), 32'(bus.tx_data), 32'(vecs[i].data));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].strobe));
      bus.req_valid = '0;
      if (vecs[i].strobe) begin
        bus.tx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d_back_idle", i), 32'(bus.busy), 32'd0);
      end
    end

    // Fairness: all four requesting, 40-cycle transmitter.
    do_reset();
    exp_q.push_back({2'd0, 8'h55});
    exp_q.push_back({2'd1, 8'h22});
    exp_q.push_back({2'd2, 8'h33});
    exp_q.push_back({2'd3, 8'h44});
    exp_q.push_back({2'd0, 8'h55});
    stale_len = 0;
    busy_len  = 40;
    model_en  = 1'b1;
    mon_en    = 1'b1;
    bus.req_valid = 4'b1111;
    begin
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < 400) begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.req_valid = '0;
    wait_idle(100);
    mon_en = 1'b0;

    // Stale ready: ready stays high one cycle after the strobe, then low 30.
    do_reset();
    begin
      logic second = 1'b0;
      int   cyc    = 0;
      @(negedge clk);
      bus.req_valid = 4'b0001;
      bus.tx_ready  = 1'b1;
      @(negedge clk);
      check("stale_first_strobe", 32'(bus.tx_strobe), 32'd1);
      @(negedge clk);
      if (bus.tx_strobe) second = 1'b1;
      check("stale_wait_low", 32'(bus.dbg_state), 32'(WAIT_LOW));
      bus.tx_ready = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (bus.tx_strobe) second = 1'b1;
      end
      check("stale_no_early_strobe", 32'(second), 32'd0);
      bus.tx_ready = 1'b1;
      while (!bus.tx_strobe && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      check("stale_regrant_latency", 32'(cyc), 32'd2);
      check("stale_regrant_owner", 32'(bus.owner), 32'd0);
    end

    // Mid-byte reset during WAIT_HIGH, then requester 2 alone.
    do_reset();
    begin
      logic ack_seen = 1'b0;
      @(negedge clk);
      bus.req_valid = 4'b0001;
      bus.tx_ready  = 1'b1;
      @(negedge clk);
      check("mid_first_ack", 32'(bus.req_ack), 32'b0001);
      bus.req_valid = '0;
      bus.tx_ready  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_in_wait_high", 32'(bus.dbg_state), 32'(WAIT_HIGH));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.tx_ready = 1'b1;
      check("mid_reset_busy", 32'(bus.busy), 32'd0);
      check("mid_reset_owner", 32'(bus.owner), 32'd3);
      check("mid_reset_tx_data", 32'(bus.tx_data), 32'd0);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (bus.req_ack != '0 || bus.tx_strobe) ack_seen = 1'b1;
      end
      check("mid_no_ack_after_reset", 32'(ack_seen), 32'd0);
      bus.req_valid = 4'b0100;
      @(negedge clk);
      check("mid_next_strobe", 32'(bus.tx_strobe), 32'd1);
      check("mid_next_owner", 32'(bus.owner), 32'd2);
      check("mid_next_ack", 32'(bus.req_ack), 32'b0100);
      check("mid_next_data", 32'(bus.tx_data), 32'h33);
      bus.req_valid = '0;
    end

    // Message lock: requester 1 sends A0,A1,A2 (last on A2), requester 2 sends B0.
    do_reset();
`ifdef UART_TX_ARB_LOCK_EN
    exp_q.push_back({2'd1, 8'hA0});
    exp_q.push_back({2'd1, 8'hA1});
    exp_q.push_back({2'd1, 8'hA2});
    exp_q.push_back({2'd2, 8'hB0});
`else
    exp_q.push_back({2'd1, 8'hA0});
    exp_q.push_back({2'd2, 8'hB0});
    exp_q.push_back({2'd1, 8'hA1});
    exp_q.push_back({2'd1, 8'hA2});
`endif
    bus.req_data  = {8'h44, 8'hB0, 8'hA0, 8'h55};
    req_last_tb   = 4'b0000;
    stale_len     = 0;
    busy_len      = 10;
    model_en      = 1'b1;
    mon_en        = 1'b1;
    bus.req_valid = 4'b0110;
    begin
      int r1_idx = 0;
      int cyc    = 0;
      while ((exp_q.size() != 0 || bus.busy) && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if (bus.req_ack[1]) begin
          r1_idx++;
          if (r1_idx == 3) begin
            bus.req_valid[1] = 1'b0;
          end else begin
            bus.req_data[15:8] = 8'hA0 + 8'(r1_idx);
            req_last_tb[1]     = (r1_idx == 2);
          end
        end
        if (bus.req_ack[2]) bus.req_valid[2] = 1'b0;
      end
      check("lock_r1_bytes", 32'(r1_idx), 32'd3);
    end
    wait_idle(50);
    check("lock_valid_cleared", 32'(bus.req_valid), 32'd0);
    mon_en = 1'b0;

    check("tx_data_stable", 32'(stable_bad), 32'd0);
    check("ack_only_in_send", 32'(ack_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
